bubble_sort_seq: RTL and testbench

Sequential word-level sorting stage for the combinational bit sorter. It collects N words of W bits over a valid/ready input stream into an internal buffer. It sorts them in place, ascending and unsigned, with one compare-swap per clock (bubble sort). It then streams the sorted words out over a valid/ready output stream, with a last marker on the final word.

---
 rtl/bubble_sort_seq.sv | 114 +++++++++++
 tb/tb_bubble_sort_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bubble_sort_seq.sv
// Sequential bubble sorter: loads N words, sorts them ascending (unsigned, stable)
// with one compare-swap per clock, then streams them out with a last marker.
module bubble_sort_seq #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);
    // Handshake: a word moves when valid && ready at a rising clk edge; ready and
    // valid are decoded from registered state only, never from the partner's signal.
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [IW-1:0] PEN  = IW'(N - 2);

    typedef enum logic [1:0] {LOAD = 2'd0, SORT = 2'd1, DRAIN = 2'd2} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] wr_idx, cmp_idx, rd_idx, cmp_nxt;
    logic          swapped;
    logic [W-1:0]  mem [N];
    logic [W-1:0]  lo_w, hi_w;
    logic          do_swap, pass_swapped;

    assign cmp_nxt      = cmp_idx + IW'(1);
    assign lo_w         = mem[cmp_idx];
    assign hi_w         = mem[cmp_nxt];
    assign do_swap      = (state == SORT) && (lo_w > hi_w);
    assign pass_swapped = swapped || do_swap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOAD;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (in_valid && wr_idx == LAST) state_nx = SORT;
            SORT:    if (cmp_idx == PEN && !pass_swapped) state_nx = DRAIN;
            DRAIN:   if (out_ready && rd_idx == LAST) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        case (state)
            LOAD:  in_ready = 1'b1;
            SORT:  busy = 1'b1;
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = (rd_idx == LAST);
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    assign out_data = mem[rd_idx];

    // Buffer and index counters; a clean pass (no swap anywhere) ends the sort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_idx  <= '0;
            cmp_idx <= '0;
            rd_idx  <= '0;
            swapped <= 1'b0;
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else begin
            case (state)
                LOAD: if (in_valid) begin
                    mem[wr_idx] <= in_data;
                    if (wr_idx == LAST) begin
                        wr_idx  <= '0;
                        cmp_idx <= '0;
                        swapped <= 1'b0;
                    end else begin
                        wr_idx <= wr_idx + IW'(1);
                    end
                end
                SORT: begin
                    if (do_swap) begin
                        mem[cmp_idx] <= hi_w;
                        mem[cmp_nxt] <= lo_w;
                    end
                    if (cmp_idx == PEN) begin
                        cmp_idx <= '0;
                        swapped <= 1'b0;
                        if (!pass_swapped) rd_idx <= '0;
                    end else begin
                        cmp_idx <= cmp_nxt;
                        swapped <= pass_swapped;
                    end
                end
                DRAIN: if (out_ready) begin
                    rd_idx <= (rd_idx == LAST) ? '0 : rd_idx + IW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bubble_sort_seq.sv
// Directed bench for bubble_sort_seq: sorted, reverse, duplicates, backpressure,
// reset mid-sort and back-to-back batches.
module tb_bubble_sort_seq;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    bubble_sort_seq #(.N(8), .W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Loads 8 words; optional random idle gaps; optionally keeps in_valid high afterwards.
    task automatic load_batch(input logic [7:0] v[8], input bit gaps, input bit hold);
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                in_valid = 1'b0;
                for (int j = 0; j < g; j++) begin
                    chk("load_idle_ready", in_ready, 1);
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = v[i];
            chk("load_ready", in_ready, 1);
            @(negedge clk);
        end
        if (!hold) in_valid = 1'b0;
        chk("after_load_ready", in_ready, 0);
        chk("after_load_busy", busy, 1);
    endtask

    // Counts SORT cycles until out_valid rises; exp_cyc of 0 skips the length check.
    task automatic wait_sort(input int exp_cyc);
        int cyc;
        cyc = 0;
        while (busy === 1'b1 && out_valid === 1'b0 && cyc < 300) begin
            chk("sort_ready", in_ready, 0);
            cyc++;
            @(negedge clk);
        end
        chk("sort_done_valid", out_valid, 1);
        if (exp_cyc > 0) chk("sort_cycles", cyc, exp_cyc);
    endtask

    // pat 0: always ready; pat 1: ready 1,0,0 repeating.
    task automatic drain(input logic [7:0] e[8], input int pat);
        int got, k;
        bit stalled;
        logic [7:0] prev, exp;
        for (int i = 0; i < 8; i++) exp_q.push_back(e[i]);
        got = 0; k = 0; stalled = 0; prev = '0;
        while (got < 8 && k < 100) begin
            out_ready = 1'b0;
            if (out_valid === 1'b1) begin
                chk("drain_busy", busy, 1);
                chk("drain_in_ready", in_ready, 0);
                chk("drain_last", out_last, (got == 7));
                if (stalled) chk("drain_hold", out_data, prev);
                out_ready = (pat == 0) ? 1'b1 : (k % 3 == 0);
                if (out_ready) begin
                    exp = exp_q.pop_front();
                    chk("drain_data", out_data, exp);
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    prev = out_data;
                end
            end else begin
                chk("drain_valid", out_valid, 1);
            end
            k++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        exp_q.delete();
        chk("drain_count", got, 8);
        chk("post_drain_ready", in_ready, 1);
        chk("post_drain_busy", busy, 0);
        chk("post_drain_valid", out_valid, 0);
    endtask

    initial begin
        logic [7:0] v[8];
        logic [7:0] e[8];
        logic [7:0] up[8];
        logic [7:0] dn[8];
        up = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        dn = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};

        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        reset = 1'b0;
        @(negedge clk);

        // already sorted
        load_batch(up, 0, 0);
        wait_sort(7);
        drain(up, 0);

        // reverse order: 8 passes of 7 compares
        load_batch(dn, 0, 0);
        wait_sort(56);
        drain(up, 0);

        // duplicates and extremes
        v = '{8'hFF, 8'h00, 8'h7F, 8'h7F, 8'h80, 8'h00, 8'hFF, 8'h01};
        e = '{8'h00, 8'h00, 8'h01, 8'h7F, 8'h7F, 8'h80, 8'hFF, 8'hFF};
        load_batch(v, 0, 0);
        wait_sort(0);
        drain(e, 0);

        // backpressure with input gaps
        v = '{8'h5A, 8'h13, 8'hC4, 8'h13, 8'h9E, 8'h02, 8'h77, 8'h40};
        e = '{8'h02, 8'h13, 8'h13, 8'h40, 8'h5A, 8'h77, 8'h9E, 8'hC4};
        load_batch(v, 1, 0);
        wait_sort(0);
        drain(e, 1);

        // reset during SORT cycle 10 of the reverse batch
        load_batch(dn, 0, 0);
        for (int i = 0; i < 9; i++) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", in_ready, 1);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_valid", out_valid, 0);
        v = '{8'd3, 8'd1, 8'd2, 8'd5, 8'd4, 8'd8, 8'd7, 8'd6};
        load_batch(v, 0, 0);
        wait_sort(0);
        drain(up, 0);

        // back-to-back: second batch's first word waits through SORT and DRAIN
        v = '{8'h10, 8'h0F, 8'hA0, 8'h33, 8'h33, 8'h01, 8'hEE, 8'h20};
        e = '{8'h01, 8'h0F, 8'h10, 8'h20, 8'h33, 8'h33, 8'hA0, 8'hEE};
        load_batch(v, 0, 1);
        v = '{8'h44, 8'h22, 8'h66, 8'h11, 8'h88, 8'h55, 8'h77, 8'h33};
        in_data = v[0];
        wait_sort(0);
        drain(e, 0);
        e = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        load_batch(v, 0, 0);
        wait_sort(0);
        drain(e, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
